// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
//   Top-level sequencer for the SDRAM controller. Owns the single SDRAM
//   command/address/data bus: holds off all traffic until initialisation has
//   finished, then grants the bus to the auto-refresh, write or read sub-module,
//   one at a time, and muxes the granted module's command, bank, address and
//   write data onto the SDRAM pins.
//
//   Optional feature macro: SDRAM_ARB_RR_EN
//     defined   -> write/read share the bus round-robin (refresh still wins);
//                  a 1-bit last-grant register remembers who was served last.
//     undefined -> fixed priority refresh > write > read.
//
// Ports
//   arb_clk, arb_rst_n              clock, asynchronous active-low reset
//   init_cmd/bank/addr, init_end    init module bus and completion level
//   ar_req/end/cmd/bank/addr, ar_en refresh request, done pulse, bus, grant
//   wr_req/end/cmd/bank/addr,
//   wr_data, wr_sdram_en, wr_en     write request, done pulse, bus, data, grant
//   rd_req/end/cmd/bank/addr, rd_en read request, done pulse, bus, grant
//   sdram_cke, sdram_cs_n/ras_n/
//   cas_n/we_n, sdram_ba/addr,
//   sdram_dq_o, sdram_dq_oe         SDRAM pins (DQ tristate lives outside)
// -----------------------------------------------------------------------------
module sdram_arbit #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 13,
   parameter int BANK_W = 2
) (
   input  logic              arb_clk,
   input  logic              arb_rst_n,
   input  logic [3:0]        init_cmd,
   input  logic [BANK_W-1:0] init_bank,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              init_end,
   input  logic              ar_req,
   input  logic              ar_end,
   input  logic [3:0]        ar_cmd,
   input  logic [BANK_W-1:0] ar_bank,
   input  logic [ADDR_W-1:0] ar_addr,
   output logic              ar_en,
   input  logic              wr_req,
   input  logic              wr_end,
   input  logic [3:0]        wr_cmd,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_sdram_en,
   output logic              wr_en,
   input  logic              rd_req,
   input  logic              rd_end,
   input  logic [3:0]        rd_cmd,
   input  logic [BANK_W-1:0] rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   output logic              sdram_cke,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [BANK_W-1:0] sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [DATA_W-1:0] sdram_dq_o,
   output logic              sdram_dq_oe
);

   localparam logic [3:0] CMD_NOP = 4'b0111;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } state_e;

   state_e state_q, state_d;

   // Winner between write and read when both are requesting.
   logic   wr_wins_s;

`ifdef SDRAM_ARB_RR_EN
   // 1 = write was the last data burst granted, 0 = read (reset value).
   logic   last_wr_q, last_wr_d;

   // Serve whichever of write/read was not served last.
   always_comb begin
      wr_wins_s = ~last_wr_q;
   end

   // Track the last data grant; only updates when WRITE or READ is entered.
   always_comb begin
      last_wr_d = last_wr_q;
      if ((state_q == ST_ARBIT) && (state_d == ST_WRITE)) begin
         last_wr_d = 1'b1;
      end else if ((state_q == ST_ARBIT) && (state_d == ST_READ)) begin
         last_wr_d = 1'b0;
      end else begin
         last_wr_d = last_wr_q;
      end
   end

   // Last-grant register.
   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         last_wr_q <= 1'b0;
      end else begin
         last_wr_q <= last_wr_d;
      end
   end
`else
   // Fixed priority: write always beats read.
   always_comb begin
      wr_wins_s = 1'b1;
   end
`endif

   // State register.
   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Each burst returns to ARBIT, which guarantees one idle
   // bus cycle between consecutive grants. End pulses for other owners are
   // ignored because only the matching *_end is looked at per state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: begin
            if (init_end) begin
               state_d = ST_ARBIT;
            end else begin
               state_d = ST_INIT;
            end
         end
         ST_ARBIT: begin
            if (ar_req) begin
               state_d = ST_AREF;
            end else if (wr_req && rd_req) begin
               if (wr_wins_s) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end else if (wr_req) begin
               state_d = ST_WRITE;
            end else if (rd_req) begin
               state_d = ST_READ;
            end else begin
               state_d = ST_ARBIT;
            end
         end
         ST_AREF: begin
            if (ar_end) begin
               state_d = ST_ARBIT;
            end else begin
               state_d = ST_AREF;
            end
         end
         ST_WRITE: begin
            if (wr_end) begin
               state_d = ST_ARBIT;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_READ: begin
            if (rd_end) begin
               state_d = ST_ARBIT;
            end else begin
               state_d = ST_READ;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Grant decode straight from state, so at most one grant is ever high.
   always_comb begin
      ar_en = (state_q == ST_AREF);
      wr_en = (state_q == ST_WRITE);
      rd_en = (state_q == ST_READ);
   end

   // Pin mux. While reset is asserted the bus is forced to NOP/all-ones even
   // though the state is INIT, so a mid-burst reset idles the pins at once.
   always_comb begin
      logic [3:0] cmd_s;
      cmd_s      = CMD_NOP;
      sdram_ba   = {BANK_W{1'b1}};
      sdram_addr = {ADDR_W{1'b1}};
      if (!arb_rst_n) begin
         cmd_s      = CMD_NOP;
         sdram_ba   = {BANK_W{1'b1}};
         sdram_addr = {ADDR_W{1'b1}};
      end else begin
         case (state_q)
            ST_INIT: begin
               cmd_s      = init_cmd;
               sdram_ba   = init_bank;
               sdram_addr = init_addr;
            end
            ST_AREF: begin
               cmd_s      = ar_cmd;
               sdram_ba   = ar_bank;
               sdram_addr = ar_addr;
            end
            ST_WRITE: begin
               cmd_s      = wr_cmd;
               sdram_ba   = wr_bank;
               sdram_addr = wr_addr;
            end
            ST_READ: begin
               cmd_s      = rd_cmd;
               sdram_ba   = rd_bank;
               sdram_addr = rd_addr;
            end
            default: begin
               cmd_s      = CMD_NOP;
               sdram_ba   = {BANK_W{1'b1}};
               sdram_addr = {ADDR_W{1'b1}};
            end
         endcase
      end
      sdram_cs_n  = cmd_s[3];
      sdram_ras_n = cmd_s[2];
      sdram_cas_n = cmd_s[1];
      sdram_we_n  = cmd_s[0];
   end

   // DQ drive: data is always passed through; only the enable is qualified.
   always_comb begin
      sdram_cke   = 1'b1;
      sdram_dq_o  = wr_data;
      sdram_dq_oe = (state_q == ST_WRITE) && wr_sdram_en;
   end

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;

   logic        arb_clk = 1'b0;
   logic        arb_rst_n;
   logic [3:0]  init_cmd;
   logic [1:0]  init_bank;
   logic [12:0] init_addr;
   logic        init_end;
   logic        ar_req, ar_end;
   logic [3:0]  ar_cmd;
   logic [1:0]  ar_bank;
   logic [12:0] ar_addr;
   logic        ar_en;
   logic        wr_req, wr_end;
   logic [3:0]  wr_cmd;
   logic [1:0]  wr_bank;
   logic [12:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_sdram_en;
   logic        wr_en;
   logic        rd_req, rd_end;
   logic [3:0]  rd_cmd;
   logic [1:0]  rd_bank;
   logic [12:0] rd_addr;
   logic        rd_en;
   logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;
   logic [15:0] sdram_dq_o;
   logic        sdram_dq_oe;

   int tests = 0;
   int fails = 0;

   sdram_arbit #(.DATA_W(16), .ADDR_W(13), .BANK_W(2)) dut (
      .arb_clk(arb_clk), .arb_rst_n(arb_rst_n),
      .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr), .init_end(init_end),
      .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr),
      .ar_en(ar_en),
      .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_sdram_en(wr_sdram_en), .wr_en(wr_en),
      .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
      .rd_en(rd_en),
      .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
      .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
      .sdram_addr(sdram_addr), .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe)
   );

   always #5 arb_clk = ~arb_clk;

   task automatic tick();
      @(posedge arb_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {ar_en, wr_en, rd_en}
   task automatic chk_gnt(input string tag, input logic [2:0] exp);
      chk(tag, {29'd0, ar_en, wr_en, rd_en}, {29'd0, exp});
   endtask

   // {cmd, ba, addr}
   task automatic chk_pins(input string tag, input logic [3:0] c, input logic [1:0] b,
                           input logic [12:0] a);
      chk(tag, {13'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
          {13'd0, c, b, a});
   endtask

   // Expected grant order for wr_req & rd_req held together, entered with
   // WRITE as the most recent data grant.
`ifdef SDRAM_ARB_RR_EN
   logic [2:0] fair_exp [3] = '{3'b001, 3'b010, 3'b001};
`else
   logic [2:0] fair_exp [3] = '{3'b010, 3'b010, 3'b010};
`endif

   initial begin
      arb_rst_n   = 1'b0;
      init_cmd    = 4'b0010; init_bank = 2'b01; init_addr = 13'h0400; init_end = 1'b0;
      ar_req = 1'b1; ar_end = 1'b0; ar_cmd = 4'b0001; ar_bank = 2'b00; ar_addr = 13'h0000;
      wr_req = 1'b1; wr_end = 1'b0; wr_cmd = 4'b0100; wr_bank = 2'b10; wr_addr = 13'h0123;
      wr_data = 16'hA5A5; wr_sdram_en = 1'b1;
      rd_req = 1'b1; rd_end = 1'b0; rd_cmd = 4'b0101; rd_bank = 2'b11; rd_addr = 13'h0456;

      // Held in reset
      tick(); tick();
      chk_gnt("rst_gnt", 3'b000);
      chk_pins("rst_pins", 4'b0111, 2'b11, 13'h1FFF);
      chk("rst_oe", {31'd0, sdram_dq_oe}, 32'd0);
      chk("rst_cke", {31'd0, sdram_cke}, 32'd1);

      // Released, init not done, all requests high: stays INIT
      arb_rst_n = 1'b1;
      tick(); tick(); tick();
      chk_gnt("init_gnt", 3'b000);
      chk_pins("init_pins", 4'b0010, 2'b01, 13'h0400);
      chk("init_oe", {31'd0, sdram_dq_oe}, 32'd0);

      // init_end with refresh + write pending: refresh first
      init_end = 1'b1; rd_req = 1'b0;
      tick();
      chk_gnt("arb1_gnt", 3'b000);
      chk_pins("arb1_pins", 4'b0111, 2'b11, 13'h1FFF);
      tick();
      chk_gnt("aref_gnt", 3'b100);
      chk_pins("aref_pins", 4'b0001, 2'b00, 13'h0000);
      chk("aref_oe", {31'd0, sdram_dq_oe}, 32'd0);
      tick();
      chk_gnt("aref_hold", 3'b100);
      ar_end = 1'b1; ar_req = 1'b0;
      tick();
      ar_end = 1'b0;
      chk_gnt("arb2_gnt", 3'b000);
      tick();
      chk_gnt("wr_gnt", 3'b010);
      chk_pins("wr_pins", 4'b0100, 2'b10, 13'h0123);
      chk("wr_dq", {16'd0, sdram_dq_o}, 32'h0000A5A5);
      chk("wr_oe", {31'd0, sdram_dq_oe}, 32'd1);
      wr_sdram_en = 1'b0; #1;
      chk("wr_oe_off", {31'd0, sdram_dq_oe}, 32'd0);
      wr_sdram_en = 1'b1;

      // Refresh request mid write, plus a stray rd_end: write keeps the bus
      ar_req = 1'b1; rd_end = 1'b1;
      tick();
      rd_end = 1'b0;
      chk_gnt("wr_keep", 3'b010);
      wr_end = 1'b1;
      tick();
      wr_end = 1'b0;
      chk_gnt("arb3_gnt", 3'b000);
      tick();
      chk_gnt("aref2_gnt", 3'b100);
      ar_end = 1'b1; ar_req = 1'b0; rd_req = 1'b1;
      tick();
      ar_end = 1'b0;
      chk_gnt("arb4_gnt", 3'b000);

      // Write and read both held
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_gnt($sformatf("fair%0d_gnt", i), fair_exp[i]);
         chk($sformatf("fair%0d_oe", i), {31'd0, sdram_dq_oe}, {31'd0, fair_exp[i][1]});
         if (fair_exp[i][1]) wr_end = 1'b1; else rd_end = 1'b1;
         tick();
         wr_end = 1'b0; rd_end = 1'b0;
         chk_gnt($sformatf("fair%0d_arb", i), 3'b000);
      end

      // Read only, then reset mid-read
      wr_req = 1'b0;
      tick();
      chk_gnt("rd_gnt", 3'b001);
      chk_pins("rd_pins", 4'b0101, 2'b11, 13'h0456);
      chk("rd_oe", {31'd0, sdram_dq_oe}, 32'd0);
      #2 arb_rst_n = 1'b0; init_end = 1'b0; rd_req = 1'b0;
      #1;
      chk_gnt("rd_rst_gnt", 3'b000);
      chk_pins("rd_rst_pins", 4'b0111, 2'b11, 13'h1FFF);
      tick();
      arb_rst_n = 1'b1;
      tick(); tick();
      chk_gnt("reinit_gnt", 3'b000);
      chk_pins("reinit_pins", 4'b0010, 2'b01, 13'h0400);

      // Idle ARBIT with no requests, then a read
      init_end = 1'b1;
      tick(); tick();
      chk_gnt("idle_gnt", 3'b000);
      chk_pins("idle_pins", 4'b0111, 2'b11, 13'h1FFF);
      rd_req = 1'b1;
      tick();
      chk_gnt("rd2_gnt", 3'b001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
